// File: rtl/panel_debounce.sv
// -----------------------------------------------------------------------------
// panel_debounce
//
// Front-panel button conditioner for the Altair machine on the ULX3S.
// Each button is an independent channel:
//   raw pin -> polarity normalise -> 2-flop synchroniser -> counter debounce
//   -> registered level plus one-cycle press/release pulses, with an optional
//   hold-to-repeat FSM that re-pulses btn_press while the button stays held.
//
// Ports
//   clk          system clock (25 MHz)
//   resetn       asynchronous, active-low reset
//   btn_raw      raw, unsynchronised button pins
//   btn_level    debounced level, 1 = pressed
//   btn_press    one-cycle pulse on each accepted press and on each repeat
//   btn_release  one-cycle pulse on each accepted release
//
// All outputs come straight from flops; there is no combinational path from
// btn_raw to any output.
// -----------------------------------------------------------------------------
module panel_debounce #(
    parameter int unsigned       N_BTN           = 6,
    parameter int unsigned       DEBOUNCE_CYCLES = 250000,
    parameter int unsigned       REPEAT_DELAY    = 12500000,
    parameter int unsigned       REPEAT_PERIOD   = 2500000,
    parameter logic [N_BTN-1:0]  ACTIVE_LOW_MASK = N_BTN'(1),
    parameter logic [N_BTN-1:0]  REPEAT_MASK     = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned R_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RCNT_W = $clog2(R_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic              meta_q, meta_d;
        logic              sync_q, sync_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic              level_q, level_d;
        logic              press_q, press_d;
        logic              release_q, release_d;
        rpt_state_e        state_q, state_d;
        logic [RCNT_W-1:0] rcnt_q, rcnt_d;
        logic              accept;

        always_comb begin
            // Synchroniser stage: normalise so that 1 always means pressed.
            meta_d    = btn_raw[i] ^ ACTIVE_LOW_MASK[i];
            sync_d    = meta_q;

            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            state_d   = state_q;
            rcnt_d    = rcnt_q;
            accept    = 1'b0;

            // Debounce stage: any cycle agreeing with the current level
            // restarts the count, so a glitch never accumulates.
            if (sync_q != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    accept  = 1'b1;
                    level_d = sync_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end

            // Pulses are raised on the same edge that updates the level, so
            // they coincide with the first cycle of the new level.
            press_d   = accept & sync_q;
            release_d = accept & ~sync_q;

            // Repeat stage: a falling level wins over any repeat due now.
            if (accept && !sync_q) begin
                state_d = ST_IDLE;
                rcnt_d  = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept && sync_q && REPEAT_MASK[i]) begin
                            state_d = ST_DELAY;
                            rcnt_d  = '0;
                        end
                    end
                    ST_DELAY: begin
                        if (rcnt_q == DELAY_LAST) begin
                            press_d = 1'b1;
                            rcnt_d  = '0;
                            state_d = ST_REPEAT;
                        end else begin
                            rcnt_d = rcnt_q + RCNT_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (rcnt_q == PERIOD_LAST) begin
                            press_d = 1'b1;
                            rcnt_d  = '0;
                        end else begin
                            rcnt_d = rcnt_q + RCNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        rcnt_d  = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                meta_q    <= 1'b0;
                sync_q    <= 1'b0;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                state_q   <= ST_IDLE;
                rcnt_q    <= '0;
            end else begin
                meta_q    <= meta_d;
                sync_q    <= sync_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                state_q   <= state_d;
                rcnt_q    <= rcnt_d;
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
    end

endmodule

// File: tb/tb_panel_debounce.sv
// -----------------------------------------------------------------------------
// tb_panel_debounce
//
// Directed bench for panel_debounce with short timing parameters. Expected
// pulse events are queued when a button is driven and retired on the cycle
// they are due; every cycle the outputs are compared with the events due
// then (nothing due means no pulses) and with the level implied by them.
// -----------------------------------------------------------------------------
module tb_panel_debounce;

    localparam int N   = 6;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;
    localparam logic [N-1:0] AL_MASK  = 6'b000001;
    localparam logic [N-1:0] REP_MASK = 6'b001000;

    // Input changed between edges c and c+1 is captured at edge k=c+1; the
    // new level and its pulse appear after edge k+1+DEB.
    localparam int LAT = 2 + DEB;

    logic         clk;
    logic         resetn;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;

    typedef struct {
        int           cyc;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] lset;
        logic [N-1:0] lclr;
    } ev_t;

    ev_t          sb[$];
    logic [N-1:0] exp_level;
    int           cyc;
    int           vectors;
    int           miscompares;

    panel_debounce #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .ACTIVE_LOW_MASK (AL_MASK),
        .REPEAT_MASK     (REP_MASK)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic push_ev(input int at, input logic [N-1:0] p, input logic [N-1:0] r,
                           input logic [N-1:0] s, input logic [N-1:0] c);
        ev_t e;
        e.cyc = at; e.press = p; e.rel = r; e.lset = s; e.lclr = c;
        sb.push_back(e);
    endtask

    task automatic push_press(input int ch, input int at);
        logic [N-1:0] m;
        m = 6'b000001 << ch;
        push_ev(at, m, '0, m, '0);
    endtask

    task automatic push_rep(input int ch, input int at);
        logic [N-1:0] m;
        m = 6'b000001 << ch;
        push_ev(at, m, '0, '0, '0);
    endtask

    task automatic push_rel(input int ch, input int at);
        logic [N-1:0] m;
        m = 6'b000001 << ch;
        push_ev(at, '0, m, '0, m);
    endtask

    // Repeats for a press accepted at a, stopping before the release at r.
    task automatic push_reps(input int ch, input int a, input int r);
        for (int t = a + RD; t < r; t += RP) push_rep(ch, t);
    endtask

    task automatic tick();
        logic [N-1:0] ep, er, es, ec;
        @(posedge clk);
        cyc++;
        #1;
        ep = '0; er = '0; es = '0; ec = '0;
        for (int j = sb.size() - 1; j >= 0; j--) begin
            if (sb[j].cyc == cyc) begin
                ep |= sb[j].press;
                er |= sb[j].rel;
                es |= sb[j].lset;
                ec |= sb[j].lclr;
                sb.delete(j);
            end
        end
        exp_level = (exp_level | es) & ~ec;
        check("press", btn_press, ep);
        check("release", btn_release, er);
        check("level", btn_level, exp_level);
    endtask

    initial begin
        int c, a, a2;
        cyc         = 0;
        vectors     = 0;
        miscompares = 0;
        exp_level   = '0;
        resetn      = 1'b0;
        btn_raw     = 6'b000001;

        // Reset state, then quiet with active-low button 0 released.
        repeat (3) tick();
        resetn = 1'b1;
        repeat (8) tick();

        // Clean press/release on button 1.
        c = cyc; btn_raw[1] = 1'b1; push_press(1, c + LAT);
        repeat (20) tick();
        c = cyc; btn_raw[1] = 1'b0; push_rel(1, c + LAT);
        repeat (10) tick();

        // Bounce rejection on button 2.
        btn_raw[2] = 1'b1; repeat (3) tick();
        btn_raw[2] = 1'b0; tick();
        btn_raw[2] = 1'b1; repeat (3) tick();
        btn_raw[2] = 1'b0; tick();
        c = cyc; btn_raw[2] = 1'b1; push_press(2, c + LAT);
        repeat (12) tick();
        c = cyc; btn_raw[2] = 1'b0; push_rel(2, c + LAT);
        repeat (10) tick();

        // Active-low button 0.
        c = cyc; btn_raw[0] = 1'b0; push_press(0, c + LAT);
        repeat (10) tick();
        c = cyc; btn_raw[0] = 1'b1; push_rel(0, c + LAT);
        repeat (10) tick();

        // Auto-repeat on button 3: held 30 cycles after acceptance.
        c = cyc; a = c + LAT; btn_raw[3] = 1'b1;
        push_press(3, a); push_reps(3, a, a + 30 + LAT);
        repeat (LAT + 30) tick();
        c = cyc; btn_raw[3] = 1'b0; push_rel(3, c + LAT);
        repeat (15) tick();

        // Same hold on button 4, which has no repeat.
        c = cyc; a = c + LAT; btn_raw[4] = 1'b1; push_press(4, a);
        repeat (LAT + 30) tick();
        c = cyc; btn_raw[4] = 1'b0; push_rel(4, c + LAT);
        repeat (15) tick();

        // Reset with button 3 repeating and button 1 mid-debounce.
        c = cyc; a = c + LAT; btn_raw[3] = 1'b1;
        push_press(3, a); push_rep(3, a + RD); push_rep(3, a + RD + RP);
        repeat (LAT + RD + 1) tick();
        btn_raw[1] = 1'b1;
        repeat (4) tick();
        #2;
        resetn = 1'b0;
        sb.delete();
        exp_level = '0;
        #1;
        check("rst_level", btn_level, '0);
        check("rst_press", btn_press, '0);
        check("rst_release", btn_release, '0);
        repeat (3) tick();
        resetn = 1'b1;
        c = cyc; a2 = c + LAT;
        push_press(3, a2); push_press(1, a2); push_reps(3, a2, c + 20 + LAT);
        repeat (20) tick();
        c = cyc; btn_raw[1] = 1'b0; btn_raw[3] = 1'b0;
        push_rel(1, c + LAT); push_rel(3, c + LAT);
        repeat (12) tick();

        // All six buttons at the same edge.
        c = cyc; a = c + LAT; btn_raw = 6'b111110;
        for (int ch = 0; ch < N; ch++) push_press(ch, a);
        push_reps(3, a, c + 20 + LAT);
        repeat (20) tick();
        c = cyc; btn_raw = 6'b000001;
        for (int ch = 0; ch < N; ch++) push_rel(ch, c + LAT);
        repeat (12) tick();

        vectors++;
        assert (sb.size() == 0) else begin
            miscompares++;
            $error("FAIL sb_empty observed=%0d expected=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
